uart_rx: RTL and testbench

- Receiver stage directly downstream of the team's UART transmitter; consumes its serial line.
- Line format matches the transmitter exactly:
  - idle low;
  - start bit high;
  - 8 data bits, LSB first;
  - stop bit low.
- Oversamples the line on a single reference clock, centre-samples each bit and presents the received byte through a valid/rd holding register.
- Reports framing errors and overruns.

---
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: start-high/stop-low framing, DIV-times oversampled, centre-sampled, LSB first.
// Byte valid DIV/2+9*DIV+3 cycles after the line rises; rd pops it, and an unread byte causes a drop (overrun) rather than a stall.
module uart_rx #(
    parameter int DIV = 16
) (
    input  logic       ref_clk,
    input  logic       reset,
    input  logic       in,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state;
    logic          s1;
    logic          in_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sr;
    logic          good;
    logic          take;

    assign good = (state == STOP) && (cnt == BIT_LAST) && !in_s;
    assign take = valid && rd;
    assign busy = (state != IDLE);

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state     <= IDLE;
            s1        <= 1'b0;
            in_s      <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            sr        <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            s1        <= in;
            in_s      <= s1;
            frame_err <= 1'b0;

            if (take) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
            // A pop in the completion cycle frees the register for the new byte.
            if (good) begin
                if (valid && !rd) begin
                    overrun <= 1'b1;
                end else begin
                    data  <= sr;
                    valid <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (in_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= in_s ? DATA : IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        sr  <= {in_s, sr[7:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (in_s) begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // A line stuck high must fall before another start bit is accepted.
                BRK: begin
                    if (!in_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed plus random frames for uart_rx at DIV=4, checked against a rule-level model of the byte register.
module tb_uart_rx;
    localparam int DIV = 4;

    logic       ref_clk = 1'b0;
    logic       reset;
    logic       in;
    logic       rd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovr   = 1'b0;

    uart_rx #(.DIV(DIV)) dut (
        .ref_clk   (ref_clk),
        .reset     (reset),
        .in        (in),
        .rd        (rd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame is start(1), b[0..7], stop; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        logic [9:0] f;
        f = {stop_val, b, 1'b1};
        for (int i = 0; i < 10; i++) begin
            in = f[i];
            repeat (DIV) tick();
        end
    endtask

    task automatic model_complete(input logic [7:0] b, input logic rd_now);
        if (exp_valid && !rd_now) begin
            exp_ovr = 1'b1;
        end else begin
            exp_data  = b;
            exp_valid = 1'b1;
            if (rd_now) exp_ovr = 1'b0;
        end
    endtask

    task automatic model_rd();
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        model_rd();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_data"}, data, exp_data);
        chk({tag, "_valid"}, {7'd0, valid}, {7'd0, exp_valid});
        chk({tag, "_ovr"}, {7'd0, overrun}, {7'd0, exp_ovr});
    endtask

    initial begin
        logic [7:0] b;
        int gap;

        reset = 1'b1;
        in    = 1'b0;
        rd    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_data", data, 8'h00);
        for (int i = 0; i < 50; i++) begin
            chk("idle_flags", {4'd0, valid, busy, frame_err, overrun}, 8'h00);
            tick();
        end

        // Single frame: valid appears exactly 41 cycles after the line rises.
        send_frame(8'hA9, 1'b0);
        chk("a9_pre_valid", {7'd0, valid}, 8'h00);
        tick();
        model_complete(8'hA9, 1'b0);
        chk_model("a9");
        pulse_rd();
        chk_model("a9_rd");

        // One-cycle glitch: START entered, rejected at mid-bit.
        in = 1'b1;
        tick();
        in = 1'b0;
        repeat (2) tick();
        chk("glitch_busy", {7'd0, busy}, 8'h01);
        repeat (2) tick();
        chk("glitch_idle", {7'd0, busy}, 8'h00);
        repeat (4) tick();
        chk("glitch_valid", {7'd0, valid}, 8'h00);

        // Back-to-back frames without a pop: second byte dropped.
        send_frame(8'hB2, 1'b0);
        send_frame(8'hC3, 1'b0);
        tick();
        model_complete(8'hB2, 1'b0);
        model_complete(8'hC3, 1'b0);
        chk_model("b2c3");
        chk("b2c3_ovr_set", {7'd0, overrun}, 8'h01);
        pulse_rd();
        chk_model("b2c3_rd");

        // Framing error with the line held high.
        send_frame(8'h55, 1'b1);
        chk("ferr_pre", {7'd0, frame_err}, 8'h00);
        tick();
        chk("ferr_strobe", {7'd0, frame_err}, 8'h01);
        chk_model("ferr");
        tick();
        chk("ferr_once", {7'd0, frame_err}, 8'h00);
        repeat (18) tick();
        chk("break_busy", {7'd0, busy}, 8'h01);
        chk("break_valid", {7'd0, valid}, 8'h00);
        in = 1'b0;
        repeat (4) tick();
        chk("break_exit", {7'd0, busy}, 8'h00);
        send_frame(8'hD4, 1'b0);
        tick();
        model_complete(8'hD4, 1'b0);
        chk_model("d4");
        pulse_rd();

        // Pop in the very cycle a second frame completes.
        send_frame(8'h3C, 1'b0);
        tick();
        model_complete(8'h3C, 1'b0);
        chk_model("3c");
        send_frame(8'h7E, 1'b0);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        model_complete(8'h7E, 1'b1);
        chk_model("coinc");

        // Reset in the middle of the data bits.
        in = 1'b1;
        repeat (DIV) tick();
        in = 1'b0;
        repeat (3 * DIV) tick();
        chk("mid_busy", {7'd0, busy}, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_data = 8'h00; exp_valid = 1'b0; exp_ovr = 1'b0;
        chk("rst_flags", {4'd0, valid, busy, frame_err, overrun}, 8'h00);
        chk("rst_data", data, 8'h00);
        repeat (4) tick();
        send_frame(8'h96, 1'b0);
        tick();
        model_complete(8'h96, 1'b0);
        chk_model("post_rst");
        pulse_rd();

        // Random bytes, gaps and pop delays.
        for (int n = 0; n < 10; n++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 5);
            repeat (gap) tick();
            send_frame(b, 1'b0);
            chk("rnd_pre", {7'd0, valid}, 8'h00);
            tick();
            model_complete(b, 1'b0);
            chk_model("rnd");
            gap = $urandom_range(0, 6);
            repeat (gap) tick();
            chk_model("rnd_hold");
            pulse_rd();
            chk_model("rnd_rd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
